// File: rtl/axi_rw_master.sv
// Single-outstanding AXI4 master: converts a simple request/response port into
// INCR read bursts and single-beat writes on a 64-bit bus.
// Optional build macro AXI_RW_MASTER_PROTO_CHECK_EN adds an R-channel beat counter.
// When that macro is defined, the counter flags rid/rlast protocol errors on resp_err.
module axi_rw_master #(
  parameter logic [3:0] AXI_ID    = 4'h0,
  parameter logic [7:0] MAX_ARLEN = 8'd7
) (
  input  logic        aclk,
  input  logic        areset,
  // core request/response port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_len,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_last,
  output logic        resp_err,
  // AR channel
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [31:0] awaddr,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StWr, StB} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [7:0]  len_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        aw_done_q, w_done_q;
  logic        req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic        proto_err;

  assign req_hs = req_valid & req_ready;
  assign ar_hs  = arvalid & arready;
  assign r_hs   = rvalid & rready;
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready;

  // Payloads come straight from the latched request, so they are stable while valid is high.
  assign araddr  = addr_q;
  assign arid    = AXI_ID;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign awaddr  = addr_q;
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Latch the request payload on acceptance; read length is clamped to MAX_ARLEN.
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q  <= '0;
      size_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (req_hs) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      len_q   <= (req_len > MAX_ARLEN) ? MAX_ARLEN : req_len;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  // Track AW and W handshakes separately so each valid drops on its own.
  always_ff @(posedge aclk) begin
    if (areset || req_hs) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
    end
  end

`ifdef AXI_RW_MASTER_PROTO_CHECK_EN
  logic [7:0] beat_cnt_q;

  // Count R beats of the current burst; cleared while the address is being issued.
  always_ff @(posedge aclk) begin
    if (areset || state_q == StAr) beat_cnt_q <= '0;
    else if (r_hs)                 beat_cnt_q <= beat_cnt_q + 8'd1;
  end

  assign proto_err = (rid != AXI_ID) ||
                     ( rlast && (beat_cnt_q != len_q)) ||
                     (!rlast && (beat_cnt_q == len_q));
`else
  logic unused_rid;
  assign unused_rid = ^rid;
  assign proto_err  = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_hs) state_d = req_wen ? StWr : StAr;
      StAr:   if (ar_hs) state_d = StR;
      StR:    if (r_hs && rlast) state_d = StIdle;
      StWr:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StB;
      StB:    if (b_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; R and B responses pass straight through to the core port.
  always_comb begin
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_last  = 1'b0;
    resp_err   = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StAr:   arvalid = 1'b1;
      StR: begin
        rready     = resp_ready;
        resp_valid = rvalid;
        resp_rdata = rdata;
        resp_last  = rlast;
        resp_err   = (rresp != 2'b00) || proto_err;
      end
      StWr: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
      end
      StB: begin
        bready     = resp_ready;
        resp_valid = bvalid;
        resp_last  = 1'b1;
        resp_err   = (bresp != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rw_master.sv
// Self-checking bench for axi_rw_master: directed scenarios plus randomized traffic,
// with the AXI responder and expected results generated here.
module tb_axi_rw_master;

  logic        aclk, areset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_len;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_last, resp_err;
  logic [63:0] resp_rdata;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid, rid;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [63:0] rdata, wdata;
  logic [7:0]  wstrb;

  int checks   = 0;
  int failures = 0;

  axi_rw_master dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_last(resp_last), .resp_err(resp_err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request and return after the accepting edge.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                       input logic [7:0] len, input logic [63:0] wd, input logic [7:0] ws);
    @(negedge aclk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_len = len; req_wdata = wd; req_wstrb = ws;
    #1;
    check("req_ready_idle", req_ready, 1'b1);
    @(posedge aclk);
  endtask

  // rr_mode: 0 random resp_ready, 1 always high, 2 alternating.
  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                         input int rr_mode, input bit full, input int err_beat,
                         input logic [3:0] rid_v, input int last_ovr, input int abort_beat,
                         input bit use_first, input logic [63:0] first_data, input int exp_lat);
    int  arlen_exp, last_b, b, cycles;
    bit  hs, fin, tog, err_exp;
    arlen_exp = (len > 8'd7) ? 7 : int'(len);
    last_b    = (last_ovr >= 0) ? last_ovr : arlen_exp;
    issue(1'b0, addr, size, len, {$urandom, $urandom}, 8'($urandom));
    cycles = 1;
    hs = 1'b0;
    for (int k = 0; k < 200 && !hs; k++) begin
      @(negedge aclk);
      req_valid = 1'b0; req_addr = $urandom; req_len = 8'($urandom); req_size = 3'($urandom);
      arready = full ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check("arvalid", arvalid, 1'b1);
      check("req_ready_busy", req_ready, 1'b0);
      check("araddr", araddr, addr);
      check("arlen", arlen, arlen_exp);
      check("arsize", arsize, size);
      check("arburst", arburst, 2'b01);
      check("arid", arid, 4'h0);
      hs = arready;
      @(posedge aclk);
      cycles++;
    end
    if (!hs) begin check("ar_timeout", 1'b0, 1'b1); return; end
    b = 0; fin = 1'b0; tog = 1'b0;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge aclk);
      arready = 1'b0;
      if (b == abort_beat) begin
        areset = 1'b1; rvalid = 1'b0; rlast = 1'b0; resp_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        areset = 1'b0; resp_ready = 1'b0;
        return;
      end
      rvalid = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      tog = ~tog;
      resp_ready = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? tog : 1'($urandom_range(0, 1));
      rdata = (b == 0 && use_first) ? first_data : {$urandom, $urandom};
      rlast = (b == last_b);
      rresp = (b == err_beat) ? 2'b11 : 2'b00;
      rid   = rid_v;
      #1;
      check("rready", rready, resp_ready);
      check("resp_valid_r", resp_valid, rvalid);
      if (rvalid && resp_ready) begin
        err_exp = (rresp != 2'b00);
`ifdef AXI_RW_MASTER_PROTO_CHECK_EN
        err_exp = err_exp || (rid_v != 4'h0) || ((b == arlen_exp) != rlast);
`endif
        check("resp_rdata", resp_rdata, rdata);
        check("resp_last_r", resp_last, (b == last_b));
        check("resp_err_r", resp_err, err_exp);
        if (b == last_b) fin = 1'b1;
        b++;
      end
      @(posedge aclk);
      cycles++;
    end
    if (!fin) begin check("r_timeout", 1'b0, 1'b1); return; end
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0; resp_ready = 1'b0; rresp = 2'b00; rid = 4'h0;
    #1;
    check("req_ready_after_r", req_ready, 1'b1);
    check("beats", b, last_b + 1);
    if (exp_lat > 0) check("read_latency", cycles, exp_lat);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] wd,
                          input logic [7:0] ws, input logic [1:0] bresp_v, input bit aw_late,
                          input bit full, input int exp_lat);
    int cycles;
    bit aw_d, w_d, fin;
    issue(1'b1, addr, size, 8'($urandom), wd, ws);
    cycles = 1;
    aw_d = 1'b0; w_d = 1'b0;
    for (int k = 0; k < 200 && !(aw_d && w_d); k++) begin
      @(negedge aclk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
      req_wstrb = 8'($urandom);
      wready  = (full || aw_late) ? 1'b1 : 1'($urandom_range(0, 1));
      awready = aw_late ? (k >= 3) : full ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check("awvalid", awvalid, !aw_d);
      check("wvalid", wvalid, !w_d);
      check("req_ready_busy_w", req_ready, 1'b0);
      if (!aw_d) begin
        check("awaddr", awaddr, addr);
        check("awlen", awlen, 8'd0);
        check("awsize", awsize, size);
        check("awburst", awburst, 2'b01);
        check("awid", awid, 4'h0);
      end
      if (!w_d) begin
        check("wdata", wdata, wd);
        check("wstrb", wstrb, ws);
        check("wlast", wlast, 1'b1);
      end
      if (awready) aw_d = 1'b1;
      if (wready)  w_d  = 1'b1;
      @(posedge aclk);
      cycles++;
    end
    if (!(aw_d && w_d)) begin check("wr_timeout", 1'b0, 1'b1); return; end
    fin = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge aclk);
      awready = 1'b0; wready = 1'b0;
      bvalid = full ? 1'b1 : 1'($urandom_range(0, 1));
      resp_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
      bresp = bresp_v;
      #1;
      check("bready", bready, resp_ready);
      check("resp_valid_b", resp_valid, bvalid);
      check("awvalid_b", awvalid, 1'b0);
      check("wvalid_b", wvalid, 1'b0);
      if (bvalid && resp_ready) begin
        check("resp_last_b", resp_last, 1'b1);
        check("resp_rdata_b", resp_rdata, 64'd0);
        check("resp_err_b", resp_err, bresp_v != 2'b00);
        fin = 1'b1;
      end
      @(posedge aclk);
      cycles++;
    end
    if (!fin) begin check("b_timeout", 1'b0, 1'b1); return; end
    @(negedge aclk);
    bvalid = 1'b0; resp_ready = 1'b0; bresp = 2'b00;
    #1;
    check("req_ready_after_b", req_ready, 1'b1);
    if (exp_lat > 0) check("write_latency", cycles, exp_lat);
  endtask

  initial begin
    areset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
    req_len = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    #1;
    check("rst_req_ready0", req_ready, 1'b1);
    check("rst_arvalid0", arvalid, 1'b0);
    check("rst_awvalid0", awvalid, 1'b0);
    check("rst_wvalid0", wvalid, 1'b0);
    check("rst_rready0", rready, 1'b0);
    check("rst_bready0", bready, 1'b0);
    check("rst_resp_valid0", resp_valid, 1'b0);
    areset = 1'b0; resp_ready = 1'b0;

    // Single read, full readiness: 1 beat, N+2 = 3 cycles.
    do_read(32'h8000_0000, 3'd3, 8'd0, 1, 1'b1, -1, 4'h0, -1, -1, 1'b1,
            64'h1122_3344_5566_7788, 3);
    // Burst of 4 with resp_ready alternating.
    do_read(32'h8000_0100, 3'd3, 8'd3, 2, 1'b1, -1, 4'h0, -1, -1, 1'b0, 64'd0, 0);
    // Write with awready three cycles behind wready.
    do_write(32'h8000_0010, 3'd2, 64'h0000_0000_dead_beef, 8'h0f, 2'b00, 1'b1, 1'b0, 0);
    // Write, full readiness, error response: 3 cycles.
    do_write(32'h8000_0020, 3'd3, 64'h0123_4567_89ab_cdef, 8'hff, 2'b10, 1'b0, 1'b1, 3);
    // Read error on beat 1 of a 2-beat burst.
    do_read(32'h8000_0200, 3'd3, 8'd1, 1, 1'b0, 1, 4'h0, -1, -1, 1'b0, 64'd0, 0);
    // Clamp 20 -> 7, full readiness: 8 beats in 10 cycles.
    do_read(32'h8000_0300, 3'd3, 8'd20, 1, 1'b1, -1, 4'h0, -1, -1, 1'b0, 64'd0, 10);
    // Reset during the R phase, then a clean read afterwards.
    do_read(32'h8000_0400, 3'd3, 8'd20, 1, 1'b1, -1, 4'h0, -1, 2, 1'b0, 64'd0, 0);
    do_read(32'h8000_0500, 3'd3, 8'd0, 1, 1'b1, -1, 4'h0, -1, -1, 1'b0, 64'd0, 3);
    // Bad rid, and early rlast on beat 1 of a 4-beat burst.
    do_read(32'h8000_0600, 3'd3, 8'd1, 1, 1'b1, -1, 4'h3, -1, -1, 1'b0, 64'd0, 0);
    do_read(32'h8000_0700, 3'd3, 8'd3, 1, 1'b1, -1, 4'h0, 1, -1, 1'b0, 64'd0, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom, 3'($urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom),
                 2'($urandom_range(0, 3) == 0 ? 2 : 0), 1'b0, 1'b0, 0);
      end else begin
        do_read($urandom, 3'($urandom_range(0, 3)), 8'($urandom_range(0, 12)), 0, 1'b0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                ($urandom_range(0, 7) == 0) ? 4'h5 : 4'h0, -1, -1, 1'b0, 64'd0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rw_master.md
# axi_rw_master

Single-outstanding AXI4 master that converts the core's simple memory request/response port into AXI4 read bursts and single-beat writes on a 64-bit data bus. It sits between the LSU/cache refill path and the AXI interconnect, and drives memory-side responders such as the simulation SRAM. One transaction is in flight at a time. A response, including the full read burst or the write ack, must complete before the next request is accepted.

## Interface
- AXI_ID, 4'h0: constant value driven on arid/awid and expected on rid.
- MAX_ARLEN, 8'd7: largest arlen issued; req_len is clamped to this value.

- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- req_valid / req_ready  in/out  1/1  request handshake
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_size  in  3  AXI size encoding for arsize/awsize
- req_len  in  8  read beats minus 1 (ignored for writes)
- req_wdata / req_wstrb  in  64/8  write data and byte strobes
- resp_valid / resp_ready  out/in  1/1  response handshake
- resp_rdata  out  64  read beat data (0 for write ack)
- resp_last  out  1  final read beat, or write ack
- resp_err  out  1  rresp/bresp nonzero, or protocol error (see Configuration)
- araddr, arid, arlen, arsize, arburst  out  32/4/8/3/2  AR payload
- arvalid / arready  out/in  1/1
- rid, rdata, rresp, rlast  in  4/64/2/1  R payload
- rvalid / rready  in/out  1/1
- awaddr, awid, awlen, awsize, awburst  out  32/4/8/3/2  AW payload
- awvalid / awready  out/in  1/1
- wdata, wstrb, wlast  out  64/8/1  W payload
- wvalid / wready  out/in  1/1
- bresp  in  2  B payload
- bvalid / bready  in/out  1/1

## Operation
- The FSM has five states: IDLE, AR, R, WR, B.
- req_ready = (state == IDLE). A request is accepted on req_valid && req_ready. On acceptance, addr, size, len, wdata and wstrb are latched.
- IDLE -> AR when a read is accepted; IDLE -> WR when a write is accepted.
- **AR state**
  - arvalid = 1 with the latched payload held stable.
  - arburst = 2'b01 (INCR); arlen = min(req_len, MAX_ARLEN).
  - The FSM moves to R on arvalid && arready.
- **R state**
  - rready = resp_ready; resp_valid = rvalid; resp_rdata = rdata; resp_last = rlast. These are combinational pass-throughs.
  - The FSM moves to IDLE on an rvalid && rready beat with rlast = 1.
- **WR state**
  - awvalid and wvalid are asserted together. awlen = 0, wlast = 1, awburst = INCR.
  - Each of awvalid and wvalid drops independently after its own handshake. Both handshakes may occur in the same cycle.
  - The FSM moves to B when both handshakes are done.
- **B state**
  - bready = resp_ready; resp_valid = bvalid; resp_last = 1; resp_rdata = 0.
  - The FSM moves to IDLE on bvalid && bready.
- resp_err = (rresp != 0) in R, and (bresp != 0) in B. It is evaluated per beat.
- Reset asserted mid-transaction: at the next edge the FSM returns to IDLE and all outstanding valids drop. The AXI transaction is abandoned, so the responder must be reset at the same time.

## Timing
- Reset values:
  - arvalid = awvalid = wvalid = 0.
  - rready = bready = 0.
  - resp_valid = 0.
  - req_ready = 1.
- arvalid, awvalid and wvalid are registered and rise on the cycle after the request is accepted. The minimum read latency is therefore request accept -> arvalid +1 cycle.
- Once asserted, a valid is never withdrawn before its ready arrives.
- The AR and AW payloads are stable while their valid is high.
- With back-to-back responder readiness:
  - Read burst of N beats: N+2 cycles from accept to return to IDLE.
  - Write: 3 cycles from accept to return to IDLE.
- req_ready is 0 from the acceptance cycle until the final response handshake completes. The next request can be accepted in the cycle after that handshake.

## Configuration
- **AXI_RW_MASTER_PROTO_CHECK_EN defined**
  - A beat counter is compiled in. It is cleared in AR and incremented on each R handshake.
  - resp_err is forced to 1 on any beat where:
    - rid != AXI_ID, or
    - rlast = 1 while beat count != arlen, or
    - rlast = 0 while beat count == arlen.
  - An early rlast still terminates the burst. A missing rlast keeps the FSM in R.
- **Not defined**
  - No counter exists.
  - resp_err reflects rresp/bresp only.

## Test plan
- Single read: addr 0x80000000, len 0, responder returns 0x1122334455667788 with rlast -> arlen = 0, arsize = req_size, arburst = 01; one resp beat with resp_last = 1, resp_err = 0; req_ready back to 1 the next cycle.
- Burst read: len 3, with resp_ready toggled low on alternate cycles -> rready follows resp_ready; 4 beats delivered in order; resp_last only on beat 3; no beat lost or duplicated.
- Write: addr 0x80000010, wdata 0xdeadbeef, wstrb 0x0F; awready delayed 3 cycles after wready -> wvalid drops after its handshake while awvalid is held; a single B handshake gives resp_valid with resp_last = 1.
- Error: bresp = 2'b10, and separately rresp = 2'b11 on beat 1 of a len 1 burst -> resp_err = 1 on exactly those responses.
- Clamp and reset: req_len = 20 -> arlen = 7. Then areset asserted during R -> next edge has req_ready = 1 and all valids = 0.
- With PROTO_CHECK_EN: rid = 4'h3, or rlast on beat 1 of a len 3 burst -> resp_err = 1 on the offending beat, and the FSM returns to IDLE after the early rlast.
